cksum_job_ctrl: RTL

//  Sequences checksum jobs on the FX2/DVR channel pipe: host programs a byte count, starts a job,
//  and the block arbitrates one shared 16-bit accumulator between host bytes (channel 0) and a

---
 rtl/cksum_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 19 +
 rtl/cksum_job_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cksum_pkg.sv
// Shared definitions for the checksum job controller: channel map, CTRL bit positions,
// grant vector layout and FSM state encoding.
package cksum_pkg;

    localparam logic [6:0] OFF_DATA   = 7'd0;
    localparam logic [6:0] OFF_SUM_HI = 7'd1;
    localparam logic [6:0] OFF_SUM_LO = 7'd2;
    localparam logic [6:0] OFF_CTRL   = 7'd3;
    localparam logic [6:0] OFF_LEN_HI = 7'd4;
    localparam logic [6:0] OFF_LEN_LO = 7'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_ABORT = 2;

    // Grant/request vector positions: bit 0 is the host DATA channel, bit 1 the local stream.
    localparam int GNT_HOST = 0;
    localparam int GNT_LOC  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] status_byte(input logic last_grant,
                                               input logic done,
                                               input logic busy);
        return {5'b00000, last_grant, done, busy};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Purely combinational; the last-winner pointer
// lives in the parent so it only advances on an actual transfer.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            // Contention: the requester that did not win last time goes first.
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/cksum_job_ctrl.sv
// Checksum job sequencer on the chanAddr/h2f/f2h pipe: sums exactly LEN bytes taken
// round-robin from host DATA writes and a local byte stream into one 16-bit accumulator.
module cksum_job_ctrl
    import cksum_pkg::*;
#(
    parameter int         LEN_W     = 16,
    parameter logic [6:0] CHAN_BASE = 7'd0
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [6:0]  chanAddr_in,
    input  logic [7:0]  h2fData_in,
    input  logic        h2fValid_in,
    output logic        h2fReady_out,
    output logic [7:0]  f2hData_out,
    output logic        f2hValid_out,
    input  logic        f2hReady_in,
    input  logic [7:0]  locData_in,
    input  logic        locValid_in,
    output logic        locReady_out,
    output logic [15:0] sum_out,
    output logic        busy_out,
    output logic        done_out
);

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      sum_q;
    logic [15:0]      len_q;
    logic [LEN_W-1:0] rem_q;
    logic             last_q;

    logic [6:0]       chan_off;
    logic             sel_data;
    logic             sel_sum_hi;
    logic             sel_sum_lo;
    logic             sel_ctrl;
    logic             sel_len_hi;
    logic             sel_len_lo;

    logic             ctrl_wr;
    logic             abort_req;
    logic             start_req;
    logic             cfg_open;
    logic             start_take;
    logic             run_open;
    logic [1:0]       arb_req;
    logic [1:0]       grant;
    logic             accept;
    logic [7:0]       acc_byte;
    logic             unused_f2h_ready;

    // Addresses below CHAN_BASE wrap to large offsets and fall into the default decode.
    assign chan_off   = chanAddr_in - CHAN_BASE;
    assign sel_data   = (chan_off == OFF_DATA);
    assign sel_sum_hi = (chan_off == OFF_SUM_HI);
    assign sel_sum_lo = (chan_off == OFF_SUM_LO);
    assign sel_ctrl   = (chan_off == OFF_CTRL);
    assign sel_len_hi = (chan_off == OFF_LEN_HI);
    assign sel_len_lo = (chan_off == OFF_LEN_LO);

    assign ctrl_wr    = h2fValid_in & sel_ctrl;
    assign abort_req  = ctrl_wr & h2fData_in[CTRL_ABORT];
    assign start_req  = ctrl_wr & h2fData_in[CTRL_START] & ~abort_req;
    assign cfg_open   = (state_q != RUN);
    assign start_take = start_req & cfg_open;

    // Handshake (host DATA and local stream alike): a byte transfers on a cycle where
    // valid and ready are both high. Ready is a same-cycle function of valid, is high for
    // at most one source per cycle, and is held low whenever the block cannot take a byte,
    // so an offered byte simply waits rather than being dropped.
    assign run_open = (state_q == RUN) & (rem_q != '0) & ~abort_req;
    assign arb_req  = run_open ? {locValid_in, sel_data & h2fValid_in} : 2'b00;

    rr_arb2 u_arb (
        .req   (arb_req),
        .last  (last_q),
        .grant (grant)
    );

    assign accept   = |grant;
    assign acc_byte = grant[GNT_LOC] ? locData_in : h2fData_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else if (accept && (rem_q == LEN_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else if (start_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sum_q  <= '0;
            len_q  <= '0;
            rem_q  <= '0;
            last_q <= 1'b1;
        end else begin
            if (start_take) begin
                rem_q <= LEN_W'(len_q);
                if (h2fData_in[CTRL_CLEAR]) begin
                    sum_q <= '0;
                end
            end else if (accept) begin
                sum_q  <= sum_q + {8'h00, acc_byte};
                rem_q  <= rem_q - LEN_W'(1);
                last_q <= grant[GNT_LOC];
            end
            // Configuration writes land only between jobs; during RUN they are dropped
            // without stalling the host.
            if (cfg_open && h2fValid_in) begin
                if (sel_sum_hi) begin
                    sum_q[15:8] <= h2fData_in;
                end
                if (sel_sum_lo) begin
                    sum_q[7:0] <= h2fData_in;
                end
                if (sel_len_hi) begin
                    len_q[15:8] <= h2fData_in;
                end
                if (sel_len_lo) begin
                    len_q[7:0] <= h2fData_in;
                end
            end
        end
    end

    always_comb begin
        f2hData_out = 8'h00;
        case (chan_off)
            OFF_SUM_HI: f2hData_out = sum_q[15:8];
            OFF_SUM_LO: f2hData_out = sum_q[7:0];
            OFF_CTRL:   f2hData_out = status_byte(last_q, done_out, busy_out);
            OFF_LEN_HI: f2hData_out = len_q[15:8];
            OFF_LEN_LO: f2hData_out = len_q[7:0];
            default:    f2hData_out = 8'h00;
        endcase
    end

    assign h2fReady_out     = sel_data ? grant[GNT_HOST] : 1'b1;
    assign locReady_out     = grant[GNT_LOC];
    assign f2hValid_out     = 1'b1;
    assign sum_out          = sum_q;
    assign busy_out         = (state_q == RUN);
    assign done_out         = (state_q == DONE);
    assign unused_f2h_ready = f2hReady_in;

endmodule
